// File: rtl/rr_arbiter_m.sv
// Round-robin arbiter with hold-until-release grants and an optional hold limit.
// Selection uses a lowest-set-bit ffs_m over the requests above the last winner,
// wrapping to the lowest pending request when nothing is pending above it.

// Find-first-set: returns the index of the lowest (SIDE=1) or highest (SIDE=0) set bit.
module ffs_m #(
  parameter int WIDTH     = 8,
  parameter int SIDE      = 1,
  parameter int IDX_WIDTH = $clog2((WIDTH >= 2) ? WIDTH : 2)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 valid_o
);
  // Scan so that the last match written is the winning side.
  always_comb begin
    idx_o   = '0;
    valid_o = |in_i;
    if (SIDE != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (in_i[i]) idx_o = IDX_WIDTH'(i);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (in_i[i]) idx_o = IDX_WIDTH'(i);
    end
  end
endmodule

module rr_arbiter_m #(
  parameter  int NUM_REQ   = 8,
  parameter  int MAX_HOLD  = 0,
  localparam int IDX_WIDTH = $clog2((NUM_REQ >= 2) ? NUM_REQ : 2),
  localparam int CNT_WIDTH = $clog2((MAX_HOLD >= 1) ? MAX_HOLD + 1 : 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 grant_valid,
  output logic [IDX_WIDTH-1:0] grant_idx
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  // Last count value before preemption; unused (and zero) when preemption is off.
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
    (MAX_HOLD >= 1) ? CNT_WIDTH'(MAX_HOLD - 1) : '0;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [IDX_WIDTH-1:0]   last_q, last_d;
  logic [CNT_WIDTH-1:0]   hold_cnt_q, hold_cnt_d;

  logic [NUM_REQ-1:0]     holder_bit, cand, above, hi, sel;
  logic [IDX_WIDTH-1:0]   win_idx;
  logic                   win_vld;
  logic                   holder_req, handoff;

  // Candidates exclude the current holder; prefer those above the last winner.
  always_comb begin
    holder_bit = (state_q == BUSY) ? grant_q : '0;
    cand       = req & ~holder_bit;
    above      = '0;
    for (int i = 0; i < NUM_REQ; i++)
      above[i] = (i > int'(last_q));
    hi  = cand & above;
    sel = (|hi) ? hi : cand;
  end

  ffs_m #(.WIDTH(NUM_REQ), .SIDE(1), .IDX_WIDTH(IDX_WIDTH)) u_ffs (
    .in_i    (sel),
    .idx_o   (win_idx),
    .valid_o (win_vld)
  );

  // Next-state: grant on idle, hand off on release/preempt, otherwise count hold cycles.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    holder_req = req[idx_q];
    handoff    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d          = BUSY;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          idx_d            = win_idx;
          hold_cnt_d       = '0;
        end
      end
      BUSY: begin
        // Preemption only fires under contention once the hold limit is reached.
        handoff = !holder_req ||
                  ((MAX_HOLD > 0) && win_vld && (hold_cnt_q == HOLD_LAST));
        if (handoff) begin
          last_d     = idx_q;
          hold_cnt_d = '0;
          if (win_vld) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            idx_d            = win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
          end
        end else if (win_vld && (hold_cnt_q != HOLD_LAST)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; last starts at the top index so index 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      last_q     <= IDX_WIDTH'(NUM_REQ - 1);
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = idx_q;
endmodule

// File: tb/tb_rr_arbiter_m.sv
module tb_rr_arbiter_m;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req0, req4;
  logic [0:0] req1;
  logic [3:0] g0, g4;
  logic [1:0] i0, i4;
  logic       v0, v4;
  logic [0:0] g1, i1;
  logic       v1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter_m #(.NUM_REQ(4), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .grant(g0), .grant_valid(v0), .grant_idx(i0));
  rr_arbiter_m #(.NUM_REQ(4), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .grant(g4), .grant_valid(v4), .grant_idx(i4));
  rr_arbiter_m #(.NUM_REQ(1), .MAX_HOLD(4)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .grant(g1), .grant_valid(v1), .grant_idx(i1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full output check of the 4-requester arbiters against an expected index.
  task automatic chk0(input string tag, input int idx);
    chk({tag, " grant"}, 32'(g0), (idx < 0) ? 32'h0 : (32'h1 << idx));
    chk({tag, " valid"}, 32'(v0), (idx < 0) ? 32'h0 : 32'h1);
    chk({tag, " idx"},   32'(i0), (idx < 0) ? 32'h0 : 32'(idx));
  endtask

  task automatic chk4(input string tag, input int idx);
    chk({tag, " grant"}, 32'(g4), (idx < 0) ? 32'h0 : (32'h1 << idx));
    chk({tag, " valid"}, 32'(v4), (idx < 0) ? 32'h0 : 32'h1);
    chk({tag, " idx"},   32'(i4), (idx < 0) ? 32'h0 : 32'(idx));
  endtask

  initial begin
    rst = 1'b1; req0 = '0; req4 = '0; req1 = '0;
    #12;
    chk0("reset", -1);
    chk4("reset4", -1);
    chk("reset1 grant", 32'(g1), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk0("idle", -1);

    // Back-to-back handoff; grant must not react before the edge.
    req0 = 4'b1010;
    #1 chk0("no comb path", -1);
    step();
    chk0("first grant", 1);
    req0 = 4'b1000;
    step();
    chk0("handoff", 3);

    // Wrap-around: park at idle (last=3), grant 2, then release with 0,1 pending.
    req0 = 4'b0000;
    step();
    chk0("release to idle", -1);
    req0 = 4'b0100;
    step();
    chk0("grant idx2", 2);
    req0 = 4'b0011;
    step();
    chk0("wrap to 0", 0);
    req0 = 4'b0010;
    step();
    chk0("then 1", 1);

    // Async reset while idx 3 holds.
    req0 = 4'b1000;
    step();
    chk0("hold idx3", 3);
    #3 rst = 1'b1;
    #1 chk0("async reset", -1);
    req0 = 4'b1111;
    #1 rst = 1'b0;
    step();
    chk0("post reset", 0);
    req0 = 4'b0000;

    // Preemption: each requester held exactly 4 cycles under full contention.
    req4 = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      step();
      chk4($sformatf("preempt c%0d", k), (k / 4) % 4);
    end
    req4 = 4'b0000;
    step();
    chk4("preempt drop", -1);

    // No contention: holder never preempted. Also exercise NUM_REQ=1.
    req4 = 4'b0100;
    req1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk4($sformatf("solo c%0d", k), 2);
      chk($sformatf("n1 grant c%0d", k), 32'(g1), 32'h1);
    end
    chk("n1 idx", 32'(i1), 32'h0);
    chk("n1 valid", 32'(v1), 32'h1);
    req4 = 4'b0000;
    req1 = 1'b0;
    step();
    chk4("solo drop", -1);
    chk("n1 drop", 32'(g1), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
